// File: rtl/draw_sequencer.sv
// rtl/draw_sequencer.sv - three-client draw sequencer with 1-cycle registered pixel mux to the VGA adapter
// Optional per-client watchdog is compiled in when DRAW_SEQ_TIMEOUT_EN is defined.

module draw_sequencer #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_start,
  output logic [2:0]  draw_req,
  input  logic [2:0]  client_done,
  input  logic [26:0] client_x,
  input  logic [23:0] client_y,
  input  logic [17:0] client_colour,
  input  logic [2:0]  client_write,
  output logic [8:0]  vga_x,
  output logic [7:0]  vga_y,
  output logic [5:0]  vga_colour,
  output logic        vga_write,
  output logic        busy,
  output logic        frame_done,
  output logic [2:0]  timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_RELEASE = 3'd2,
    S_NEXT    = 3'd3,
    S_FINISH  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cur_q, cur_d;
  logic [2:0]  draw_req_q, draw_req_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;
  logic [8:0]  vga_x_q, vga_x_d;
  logic [7:0]  vga_y_q, vga_y_d;
  logic [5:0]  vga_colour_q, vga_colour_d;
  logic        vga_write_q, vga_write_d;

  logic        sel_done;
  logic        sel_write;
  logic [8:0]  sel_x;
  logic [7:0]  sel_y;
  logic [5:0]  sel_colour;

`ifdef DRAW_SEQ_TIMEOUT_EN
  logic [15:0] wd_q, wd_d, wd_inc;
  logic [2:0]  tmo_err_q, tmo_err_d;

  assign wd_inc = wd_q + 16'd1;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // Select the done flag, write strobe and pixel fields of the current client
  always_comb begin
    sel_done   = client_done[0];
    sel_write  = client_write[0];
    sel_x      = client_x[8:0];
    sel_y      = client_y[7:0];
    sel_colour = client_colour[5:0];
    case (cur_q)
      2'd1: begin
        sel_done   = client_done[1];
        sel_write  = client_write[1];
        sel_x      = client_x[17:9];
        sel_y      = client_y[15:8];
        sel_colour = client_colour[11:6];
      end
      2'd2: begin
        sel_done   = client_done[2];
        sel_write  = client_write[2];
        sel_x      = client_x[26:18];
        sel_y      = client_y[23:16];
        sel_colour = client_colour[17:12];
      end
      default: ;
    endcase
  end

  // Sequencer next state; draw_req and frame_done are computed for the state being entered
  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    draw_req_d   = draw_req_q;
    frame_done_d = 1'b0;
`ifdef DRAW_SEQ_TIMEOUT_EN
    wd_d         = wd_q;
    tmo_err_d    = tmo_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        draw_req_d = 3'b000;
        if (frame_start) begin
          cur_d      = 2'd0;
          state_d    = S_REQ;
          draw_req_d = 3'b001;
`ifdef DRAW_SEQ_TIMEOUT_EN
          wd_d       = 16'd0;
          tmo_err_d  = 3'b000;
`endif
        end
      end
      S_REQ: begin
        draw_req_d = 3'b001 << cur_q;
`ifdef DRAW_SEQ_TIMEOUT_EN
        wd_d       = wd_inc;
`endif
        if (sel_done) begin
          state_d    = S_RELEASE;
          draw_req_d = 3'b000;
`ifdef DRAW_SEQ_TIMEOUT_EN
          wd_d       = 16'd0;
        end else if (wd_inc == TIMEOUT_CYCLES) begin
          tmo_err_d  = tmo_err_q | (3'b001 << cur_q);
          state_d    = S_RELEASE;
          draw_req_d = 3'b000;
          wd_d       = 16'd0;
`endif
        end
      end
      S_RELEASE: begin
        draw_req_d = 3'b000;
`ifdef DRAW_SEQ_TIMEOUT_EN
        wd_d       = wd_inc;
`endif
        if (!sel_done) begin
          state_d = S_NEXT;
`ifdef DRAW_SEQ_TIMEOUT_EN
        end else if (wd_inc == TIMEOUT_CYCLES) begin
          state_d = S_NEXT;
`endif
        end
      end
      S_NEXT: begin
        draw_req_d = 3'b000;
        if (cur_q == 2'd2) begin
          state_d      = S_FINISH;
          frame_done_d = 1'b1;
        end else begin
          cur_d      = cur_q + 2'd1;
          state_d    = S_REQ;
          draw_req_d = 3'b001 << (cur_q + 2'd1);
`ifdef DRAW_SEQ_TIMEOUT_EN
          wd_d       = 16'd0;
`endif
        end
      end
      S_FINISH: begin
        draw_req_d = 3'b000;
        state_d    = S_IDLE;
      end
      default: begin
        draw_req_d = 3'b000;
        state_d    = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Pixel path: only the selected client's pixel is captured, and only while requesting
  always_comb begin
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_write_d  = 1'b0;
    if (state_q == S_REQ) begin
      vga_x_d      = sel_x;
      vga_y_d      = sel_y;
      vga_colour_d = sel_colour;
      vga_write_d  = sel_write;
    end
  end

  // State and output registers; async reset drops requests and writes immediately
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cur_q        <= 2'd0;
      draw_req_q   <= 3'b000;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      vga_x_q      <= 9'd0;
      vga_y_q      <= 8'd0;
      vga_colour_q <= 6'd0;
      vga_write_q  <= 1'b0;
`ifdef DRAW_SEQ_TIMEOUT_EN
      wd_q         <= 16'd0;
      tmo_err_q    <= 3'b000;
`endif
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      draw_req_q   <= draw_req_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_write_q  <= vga_write_d;
`ifdef DRAW_SEQ_TIMEOUT_EN
      wd_q         <= wd_d;
      tmo_err_q    <= tmo_err_d;
`endif
    end
  end

  assign draw_req   = draw_req_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_write  = vga_write_q;
`ifdef DRAW_SEQ_TIMEOUT_EN
  assign timeout_err = tmo_err_q;
`else
  assign timeout_err = 3'b000;
`endif

endmodule

// File: tb/tb_draw_sequencer.sv
// tb/tb_draw_sequencer.sv - directed self-checking bench for draw_sequencer

module tb_draw_sequencer;

  logic        clock;
  logic        reset;
  logic        frame_start;
  logic [2:0]  draw_req;
  logic [2:0]  client_done;
  logic [26:0] client_x;
  logic [23:0] client_y;
  logic [17:0] client_colour;
  logic [2:0]  client_write;
  logic [8:0]  vga_x;
  logic [7:0]  vga_y;
  logic [5:0]  vga_colour;
  logic        vga_write;
  logic        busy;
  logic        frame_done;
  logic [2:0]  timeout_err;

  int n_cmp = 0;
  int n_bad = 0;
  int fd_count = 0;
  int oh_bad = 0;
  int busy_bad = 0;

  localparam logic [8:0] X1 = 9'd200;
  localparam logic [7:0] Y1 = 8'd100;
  localparam logic [5:0] C1 = 6'h2A;
  localparam logic [8:0] X2 = 9'd300;
  localparam logic [7:0] Y2 = 8'd200;
  localparam logic [5:0] C2 = 6'h15;

  typedef struct {
    logic       fs;
    logic [2:0] done;
    logic [2:0] wr;
    logic [8:0] x0;
    logic [7:0] y0;
    logic [5:0] c0;
    logic [2:0] e_req;
    logic       e_busy;
    logic       e_fd;
    logic       e_vw;
    logic [8:0] e_x;
    logic [7:0] e_y;
    logic [5:0] e_c;
  } vec_t;

  vec_t tbl[$];

  draw_sequencer #(.TIMEOUT_CYCLES(16'd20)) dut (
    .clock        (clock),
    .reset        (reset),
    .frame_start  (frame_start),
    .draw_req     (draw_req),
    .client_done  (client_done),
    .client_x     (client_x),
    .client_y     (client_y),
    .client_colour(client_colour),
    .client_write (client_write),
    .vga_x        (vga_x),
    .vga_y        (vga_y),
    .vga_colour   (vga_colour),
    .vga_write    (vga_write),
    .busy         (busy),
    .frame_done   (frame_done),
    .timeout_err  (timeout_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  always @(negedge clock) begin
    if (frame_done === 1'b1) fd_count++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic tick_chk();
    tick();
    if (!$onehot0(draw_req)) oh_bad++;
    if (busy !== 1'b1) busy_bad++;
  endtask

  task automatic add_vec(input logic fs, input logic [2:0] done, input logic [2:0] wr,
                         input logic [8:0] x0, input logic [7:0] y0, input logic [5:0] c0,
                         input logic [2:0] e_req, input logic e_busy, input logic e_fd,
                         input logic e_vw, input logic [8:0] e_x, input logic [7:0] e_y,
                         input logic [5:0] e_c);
    vec_t v;
    v.fs = fs; v.done = done; v.wr = wr; v.x0 = x0; v.y0 = y0; v.c0 = c0;
    v.e_req = e_req; v.e_busy = e_busy; v.e_fd = e_fd; v.e_vw = e_vw;
    v.e_x = e_x; v.e_y = e_y; v.e_c = e_c;
    tbl.push_back(v);
  endtask

  task automatic reset_dut();
    #2 reset = 1'b0;
    frame_start  = 1'b0;
    client_done  = 3'b000;
    client_write = 3'b000;
    @(posedge clock);
    #1 reset = 1'b1;
  endtask

  initial begin
    int n;
    int fd_base;
    logic [2:0] exp_req;

    reset         = 1'b0;
    frame_start   = 1'b0;
    client_done   = 3'b000;
    client_write  = 3'b000;
    client_x      = {X2, X1, 9'd0};
    client_y      = {Y2, Y1, 8'd0};
    client_colour = {C2, C1, 6'd0};

    // full pass: frame_start ignored mid-pass, foreign strobe, done+write same cycle
    //      fs    done    wr      x0     y0     c0     req     bsy  fd   vw   vx     vy     vc
    add_vec(1'b0, 3'b000, 3'b000, 9'd0,  8'd0,  6'd0,  3'b000, 1'b0,1'b0,1'b0,9'd0,  8'd0,  6'd0);
    add_vec(1'b1, 3'b000, 3'b000, 9'd0,  8'd0,  6'd0,  3'b001, 1'b1,1'b0,1'b0,9'd0,  8'd0,  6'd0);
    add_vec(1'b0, 3'b000, 3'b101, 9'd5,  8'd6,  6'd7,  3'b001, 1'b1,1'b0,1'b1,9'd5,  8'd6,  6'd7);
    add_vec(1'b0, 3'b000, 3'b100, 9'd5,  8'd6,  6'd7,  3'b001, 1'b1,1'b0,1'b0,9'd5,  8'd6,  6'd7);
    add_vec(1'b1, 3'b001, 3'b001, 9'd10, 8'd11, 6'd12, 3'b000, 1'b1,1'b0,1'b1,9'd10, 8'd11, 6'd12);
    add_vec(1'b0, 3'b001, 3'b000, 9'd10, 8'd11, 6'd12, 3'b000, 1'b1,1'b0,1'b0,9'd10, 8'd11, 6'd12);
    add_vec(1'b0, 3'b000, 3'b000, 9'd10, 8'd11, 6'd12, 3'b000, 1'b1,1'b0,1'b0,9'd10, 8'd11, 6'd12);
    add_vec(1'b0, 3'b000, 3'b000, 9'd10, 8'd11, 6'd12, 3'b010, 1'b1,1'b0,1'b0,9'd10, 8'd11, 6'd12);
    add_vec(1'b0, 3'b000, 3'b010, 9'd10, 8'd11, 6'd12, 3'b010, 1'b1,1'b0,1'b1,X1,    Y1,    C1);
    add_vec(1'b0, 3'b010, 3'b000, 9'd10, 8'd11, 6'd12, 3'b000, 1'b1,1'b0,1'b0,X1,    Y1,    C1);
    add_vec(1'b0, 3'b000, 3'b000, 9'd10, 8'd11, 6'd12, 3'b000, 1'b1,1'b0,1'b0,X1,    Y1,    C1);
    add_vec(1'b0, 3'b000, 3'b000, 9'd10, 8'd11, 6'd12, 3'b100, 1'b1,1'b0,1'b0,X1,    Y1,    C1);
    add_vec(1'b0, 3'b100, 3'b000, 9'd10, 8'd11, 6'd12, 3'b000, 1'b1,1'b0,1'b0,X2,    Y2,    C2);
    add_vec(1'b0, 3'b000, 3'b000, 9'd10, 8'd11, 6'd12, 3'b000, 1'b1,1'b0,1'b0,X2,    Y2,    C2);
    add_vec(1'b0, 3'b000, 3'b000, 9'd10, 8'd11, 6'd12, 3'b000, 1'b1,1'b1,1'b0,X2,    Y2,    C2);
    add_vec(1'b0, 3'b000, 3'b000, 9'd10, 8'd11, 6'd12, 3'b000, 1'b0,1'b0,1'b0,X2,    Y2,    C2);
    add_vec(1'b0, 3'b000, 3'b000, 9'd10, 8'd11, 6'd12, 3'b000, 1'b0,1'b0,1'b0,X2,    Y2,    C2);

    @(posedge clock);
    @(posedge clock);
    #1;
    chk("reset_outputs", {draw_req, busy, frame_done, vga_write, vga_x, vga_y, vga_colour, timeout_err},
        64'd0);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      frame_start   = tbl[i].fs;
      client_done   = tbl[i].done;
      client_write  = tbl[i].wr;
      client_x      = {X2, X1, tbl[i].x0};
      client_y      = {Y2, Y1, tbl[i].y0};
      client_colour = {C2, C1, tbl[i].c0};
      tick();
      chk($sformatf("vec%0d", i),
          {draw_req, busy, frame_done, vga_write, vga_x, vga_y, vga_colour},
          {tbl[i].e_req, tbl[i].e_busy, tbl[i].e_fd, tbl[i].e_vw, tbl[i].e_x, tbl[i].e_y, tbl[i].e_c});
    end
    frame_start  = 1'b0;
    client_done  = 3'b000;
    client_write = 3'b000;

    // clients answer 10 cycles after their request; a second frame_start lands mid-pass
    fd_base = fd_count;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_req = 3'b001 << k;
      n = 0;
      while (draw_req !== exp_req && n < 20) begin
        tick_chk();
        n++;
      end
      chk($sformatf("order_req%0d", k), draw_req, exp_req);
      for (int c = 0; c < 10; c++) begin
        if (k == 1 && c == 3) frame_start = 1'b1;
        tick_chk();
        frame_start = 1'b0;
      end
      client_done = exp_req;
      tick_chk();
      chk($sformatf("order_drop%0d", k), draw_req, 3'b000);
      client_done = 3'b000;
      tick_chk();
    end
    n = 0;
    while (busy !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    chk("pass_busy_end", busy, 1'b0);
    for (int c = 0; c < 5; c++) tick();
    chk("pass_frame_done_once", fd_count - fd_base, 1);
    chk("pass_no_requeue", {busy, draw_req}, 4'b0000);
    chk("pass_onehot", oh_bad, 0);
    chk("pass_busy_span", busy_bad, 0);

    // reset in the middle of client 1's request
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    client_done = 3'b001;
    tick();
    client_done = 3'b000;
    tick();
    tick();
    chk("rst_pre_req1", draw_req, 3'b010);
    client_write = 3'b010;
    tick();
    chk("rst_pre_write", vga_write, 1'b1);
    fd_base = fd_count;
    #3 reset = 1'b0;
    #1;
    chk("rst_async_drop", {draw_req, vga_write, busy}, 5'b00000);
    client_write = 3'b000;
    @(posedge clock);
    #1 reset = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    chk("rst_no_frame_done", fd_count - fd_base, 0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("rst_restart_client0", draw_req, 3'b001);

    // client 0 never finishes
    reset_dut();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
`ifdef DRAW_SEQ_TIMEOUT_EN
    for (int c = 0; c < 19; c++) tick();
    chk("tmo_before", {timeout_err, draw_req}, {3'b000, 3'b001});
    tick();
    chk("tmo_expire", {timeout_err, draw_req}, {3'b001, 3'b000});
    tick();
    tick();
    chk("tmo_next_client", draw_req, 3'b010);
`else
    for (int c = 0; c < 25; c++) tick();
    chk("no_tmo_waits", {timeout_err, draw_req, busy}, {3'b000, 3'b001, 1'b1});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/draw_sequencer.md
DRAW_SEQUENCER -- requirements
Module: draw_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16'd50000, is the per-client watchdog limit in clock cycles and is used only when the watchdog is compiled in.
REQ-002 clock  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 frame_start  input  1  one-cycle pulse requesting one full draw pass.
REQ-005 draw_req  output  3  one-hot level request; bit k starts client k (0=background, 1=link, 2=enemies).
REQ-006 client_done  input  3  per-client level done flag; client k holds bit k high after finishing, until draw_req[k] falls.
REQ-007 client_x  input  27  packed pixel x; client k drives bits [9k+8:9k].
REQ-008 client_y  input  24  packed pixel y; client k drives bits [8k+7:8k].
REQ-009 client_colour  input  18  packed 6-bit colour; client k drives bits [6k+5:6k].
REQ-010 client_write  input  3  per-client pixel write strobe.
REQ-011 vga_x / vga_y / vga_colour  output  9 / 8 / 6  registered pixel to VGA adapter.
REQ-012 vga_write  output  1  registered VGA write enable.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 frame_done  output  1  one-cycle pulse at the end of a pass.
REQ-015 timeout_err  output  3  sticky per-client watchdog flags.

Function
REQ-016 States: IDLE, REQ, RELEASE, NEXT, FINISH; 2-bit client index cur.
REQ-017 IDLE: on frame_start, set cur=0 and go to REQ; otherwise hold.
REQ-018 REQ: draw_req = one-hot(cur); on client_done[cur]=1, deassert draw_req and go to RELEASE.
REQ-019 RELEASE: draw_req=0; wait for client_done[cur]=0, then go to NEXT.
REQ-020 NEXT: if cur==2 go to FINISH, else increment cur and go to REQ (one idle cycle between clients).
REQ-021 FINISH: frame_done=1 for exactly one cycle, then go to IDLE.
REQ-022 At most one draw_req bit is high in any cycle.
REQ-023 frame_start while busy is ignored and is not queued.
REQ-024 Pixel path: in REQ, the vga_x/y/colour registers load client cur's fields every cycle, and vga_write is registered from client_write[cur]; latency is exactly 1 cycle.
REQ-025 In any state other than REQ, vga_write registers 0 and vga_x/y/colour hold their last value.
REQ-026 Write strobes from non-selected clients never reach vga_write.
REQ-027 client_done[cur] and client_write[cur] high in the same REQ cycle: that pixel is still forwarded.

Reset
REQ-028 While reset is low: state=IDLE, cur=0, draw_req=0, vga_x=0, vga_y=0, vga_colour=0, vga_write=0, frame_done=0, timeout_err=0, watchdog counter=0.
REQ-029 Reset asserted mid-pass drops draw_req and vga_write immediately (asynchronously), and no frame_done is produced.

Configuration
REQ-030 Macro DRAW_SEQ_TIMEOUT_EN defined: a 16-bit counter clears on entry to REQ and increments each REQ cycle; reaching TIMEOUT_CYCLES sets timeout_err[cur], drops draw_req, and goes to RELEASE.
REQ-031 In RELEASE with DRAW_SEQ_TIMEOUT_EN defined, the same counter also bounds the wait; on expiry the sequencer proceeds to NEXT.
REQ-032 timeout_err clears only on reset or on an accepted frame_start.
REQ-033 Macro not defined: no counter is built, timeout_err is tied to 0, and REQ/RELEASE wait indefinitely.

Verification
REQ-034 frame_start; each client asserts done 10 cycles after its req -> draw_req goes 001, 010, 100 in order; frame_done pulses once; busy spans the whole pass.
REQ-035 Client 1 writes x=9'd200, y=8'd100, colour=6'h2A at cycle t -> vga_* carry those values at t+1 with vga_write=1.
REQ-036 Client 2 strobes write while cur=0 -> vga_write stays 0.
REQ-037 frame_start pulsed again mid-pass -> ignored; exactly one frame_done results.
REQ-038 Reset low during client 1 REQ -> draw_req=000 and vga_write=0 that cycle; a new frame_start after release restarts at client 0.
REQ-039 With DRAW_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=20, client 0 never asserts done -> timeout_err=001 after 20 REQ cycles and client 1 is requested next.
